// File: rtl/dsp_chain_2_fp16_sop2_result_collector_pkg.sv
// Shared constants for the fp16 SOP2 multiplier array result path.
// Lane geometry and result widths used by the array and its collector.
package dsp_chain_2_fp16_sop2_result_collector_pkg;

    // Result width of one fp16 sum-of-2-products instance.
    localparam int SOP2_RES_W = 32;

    localparam int C_LANES      = 8;
    localparam int C_LANE_W     = SOP2_RES_W;
    localparam int C_VEC_W      = C_LANES * C_LANE_W;
    localparam int C_LANE_IDX_W = $clog2(C_LANES);
    localparam int C_DEPTH      = 4;

endpackage

// File: rtl/dsp_chain_2_vec_fifo.sv
// Register FIFO of whole result vectors with push/pop and occupancy.
// Ports: clk, reset, push_i, pop_i, wdata_i -> rdata_o (head), level_o,
//        full_o, empty_o. Push and pop in the same cycle are allowed
//        at full (the write lands in the slot the pop frees).
module dsp_chain_2_vec_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 256,
    localparam int PW   = $clog2(DEPTH),
    localparam int LW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [W-1:0]  wdata_i,
    output logic [W-1:0]  rdata_o,
    output logic [LW-1:0] level_o,
    output logic          full_o,
    output logic          empty_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_q;
    logic [PW-1:0] rd_q;
    logic [LW-1:0] level_q;
    logic [LW-1:0] level_d;

    always_comb begin
        level_d = level_q;
        unique case ({push_i, pop_i})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + PW'(1);
            if (pop_i)  rd_q <= rd_q + PW'(1);
            level_q <= level_d;
        end
    end

    // Storage is not cleared; level gates whether an entry is meaningful.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_q];
    assign level_o = level_q;
    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);

endmodule

// File: rtl/dsp_chain_2_fp16_sop2_result_collector.sv
// Captures 8-lane SOP2 result vectors and serializes them lane by lane.
// Ports: in_valid/in_data (free-running, no stall), in_ready (info),
//        out_valid/out_ready/out_data/out_lane/out_last stream,
//        level (vectors held), overflow (sticky drop flag).
module dsp_chain_2_fp16_sop2_result_collector
    import dsp_chain_2_fp16_sop2_result_collector_pkg::*;
#(
    parameter int LANES  = C_LANES,
    parameter int LANE_W = C_LANE_W,
    parameter int DEPTH  = C_DEPTH,
    localparam int VW    = LANES * LANE_W,
    localparam int IW    = $clog2(LANES),
    localparam int LVW   = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [VW-1:0]     in_data,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LANE_W-1:0] out_data,
    output logic [IW-1:0]     out_lane,
    output logic              out_last,
    output logic [LVW-1:0]    level,
    output logic              overflow
);

    localparam logic [IW-1:0] LAST = IW'(LANES - 1);

    logic [IW-1:0] lane_q;
    logic [IW-1:0] lane_d;
    logic          ovf_q;
    logic          ovf_d;

    logic [VW-1:0] head;
    logic          full;
    logic          empty;
    logic          fire;
    logic          at_last;
    logic          pop_vec;
    logic          push;

    assign out_valid = !empty;
    assign fire      = out_valid && out_ready;
    assign at_last   = (lane_q == LAST);
    assign pop_vec   = fire && at_last;
    // A retiring head frees its slot this edge, so a full FIFO can accept.
    assign in_ready  = !full || pop_vec;
    assign push      = in_valid && in_ready;

    dsp_chain_2_vec_fifo #(
        .DEPTH (DEPTH),
        .W     (VW)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop_vec),
        .wdata_i (in_data),
        .rdata_o (head),
        .level_o (level),
        .full_o  (full),
        .empty_o (empty)
    );

    always_comb begin
        lane_d = lane_q;
        ovf_d  = ovf_q;
        if (fire) begin
            lane_d = at_last ? '0 : lane_q + IW'(1);
        end
        if (in_valid && !in_ready) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lane_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            lane_q <= lane_d;
            ovf_q  <= ovf_d;
        end
    end

    assign out_data = head[lane_q*LANE_W +: LANE_W];
    assign out_lane = lane_q;
    assign out_last = out_valid && at_last;
    assign overflow = ovf_q;

endmodule

// File: doc/dsp_chain_2_fp16_sop2_result_collector.md
Name: dsp_chain_2_fp16_sop2_result_collector

Overview:
Downstream stage of the 8-instance fp16 sum-of-2-products multiplier array. Captures the array's 256-bit result vector (8 lanes x 32 bit) into a small vector FIFO, then serializes it lane by lane onto a 32-bit valid/ready stream toward the writeback/accumulate logic. The multiplier array is free-running and cannot stall, so this block absorbs bursts and flags overflow.

Parameters:
LANES, 8, result lanes per vector (array instance count)
LANE_W, 32, bits per lane result
DEPTH, 4, vector FIFO entries (power of 2, >=2)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high reset
in_valid  in  1  result vector valid this cycle (multiplier array's delayed valid)
in_data  in  LANES*LANE_W (256)  lane i at bits [i*32+31 : i*32]
in_ready  out  1  informational: a vector presented now will be stored
out_valid  out  1  out_data holds a valid lane word
out_ready  in  1  consumer accepts word when out_valid && out_ready
out_data  out  LANE_W  current lane word of head vector
out_lane  out  clog2(LANES) (3)  lane index of out_data
out_last  out  1  out_data is lane LANES-1 of its vector
level  out  clog2(DEPTH+1) (3)  vectors held in FIFO
overflow  out  1  sticky: a valid vector was dropped

Behaviour:
- Reset: FIFO empty, wr/rd pointers 0, lane index 0, level 0, overflow 0; out_valid 0, out_lane 0, out_last 0, in_ready 1; out_data don't-care (storage not cleared). Reset overrides all same-cycle events; mid-serialization reset discards every stored vector.
- Storage: DEPTH x 256-bit registers; write port = in_data, read = head entry selected by rd pointer.
- pop_vec = out_valid && out_ready && lane_idx == LANES-1.
- in_ready = (level != DEPTH) || pop_vec (combinational; write into the slot freed by a same-cycle retire is allowed).
- Push: in_valid && in_ready -> store at wr pointer, wr pointer +1 mod DEPTH.
- Drop: in_valid && !in_ready -> vector discarded, overflow set to 1, held until reset.
- level next = level + push - pop_vec; simultaneous push and pop_vec keeps level.
- Output: out_valid = (level != 0); out_data = head[lane_idx*32 +: 32]; out_lane = lane_idx; out_last = out_valid && lane_idx == LANES-1. All combinational from registers, no path from in_* to out_*.
- Lane counter: on out_valid && out_ready, lane_idx +1; at LANES-1 wraps to 0, rd pointer +1 mod DEPTH. Holds while !out_ready; out_data/out_lane stable while stalled.
- Latency: vector pushed at edge N -> lane 0 visible (out_valid=1) in cycle after edge N. Empty FIFO never forwards in_data in same cycle.
- Lane order strictly 0..LANES-1, vectors strictly in arrival order; no lane skipped or repeated.
- Sustained throughput: 1 vector per LANES cycles with out_ready held high; faster input fills FIFO, then drops.

Decomposition:
- Shared package: LANES, LANE_W, VEC_W = LANES*LANE_W, lane index width, fp16 SOP2 result width constant shared with multiplier array.
- One sub-module natural: dsp_chain_2_vec_fifo (DEPTH x VEC_W register FIFO with push/pop/level, concurrent push+pop at full allowed). Serializer counter and overflow flag stay in top.

Test Plan:
- Single vector: in_data lanes = 0x1000_0000+i, one-cycle in_valid, out_ready=1 -> 8 consecutive words 0x1000_0000..0x1000_0007, out_lane 0..7, out_last only on 7th index, level 1->0, overflow 0.
- Backpressure: same vector, out_ready low cycles 2-5 -> out_data/out_lane frozen at lane 1 while stalled, resumes at lane 1, total 8 words, no duplicates.
- Fill/overflow: out_ready=0, 5 back-to-back vectors (tags 0xA..0xE) -> level 4, in_ready 0 on 5th, overflow=1; release out_ready -> 32 words of tags A-D in order, E absent, overflow remains 1.
- Full with retire: FIFO full, head at lane 7 with out_ready=1, in_valid with tag 0xF same cycle -> in_ready 1, accepted, level stays 4, overflow stays 0, tag F emerges after 3 remaining vectors.
- Reset mid-operation: 3 vectors stored, reset at lane 3 of head -> next cycle out_valid 0, level 0, overflow 0; new vector afterwards serializes from lane 0.
- Streaming: in_valid every 8th cycle for 100 vectors, out_ready=1 -> all 800 words in order, level never exceeds 1, overflow 0.
